// File: rtl/tc_digital_io_ctrl.sv
// Core-side controller for a tc_digital_io pad: sequences direction changes through a hi-Z
// turnaround window, registers pad configuration and synchronises/filters returned pad data.
module tc_digital_io_ctrl #(
  parameter int unsigned TURNAROUND_CYCLES = 2,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned FILTER_DEPTH      = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dir_out_i,
  input  logic       out_data_i,
  input  logic [3:0] cfg_drv_i,
  input  logic [1:0] cfg_pull_i,
  output logic       in_data_o,
  output logic       in_valid_o,
  output logic       in_edge_o,
  output logic       out_active_o,
  output logic       busy_o,
  output logic       pad_data_o,
  input  logic       pad_data_i,
  output logic       pad_oe_no,
  output logic [3:0] pad_drv_o,
  output logic       pad_pu_o,
  output logic       pad_pd_o
);

  localparam int unsigned SettleCycles = SYNC_STAGES + FILTER_DEPTH;
  localparam int unsigned TaW  = (TURNAROUND_CYCLES > 0) ? $clog2(TURNAROUND_CYCLES + 1) : 1;
  localparam int unsigned FltW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam int unsigned SetW = $clog2(SettleCycles + 1);
  localparam logic [TaW-1:0] TaLoad = TaW'(TURNAROUND_CYCLES);

  typedef enum logic [1:0] {StIn, StTurnOut, StOut, StTurnIn} state_e;

  state_e            state_q, state_d;
  logic [TaW-1:0]    ta_cnt_q, ta_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FltW-1:0]   flt_cnt_q;
  logic [SetW-1:0]   settle_q;
  logic              sample;
  logic              flt_update;

  always_comb begin
    state_d  = state_q;
    ta_cnt_d = ta_cnt_q;
    unique case (state_q)
      StIn: begin
        if (dir_out_i) begin
          if (TURNAROUND_CYCLES == 0) begin
            state_d = StOut;
          end else begin
            state_d  = StTurnOut;
            ta_cnt_d = TaLoad;
          end
        end
      end
      StTurnOut: begin
        // Withdrawn request aborts before the pad is ever driven.
        if (!dir_out_i) begin
          state_d = StIn;
        end else if (ta_cnt_q <= TaW'(1)) begin
          state_d = StOut;
        end else begin
          ta_cnt_d = ta_cnt_q - TaW'(1);
        end
      end
      StOut: begin
        if (!dir_out_i) begin
          if (TURNAROUND_CYCLES == 0) begin
            state_d = StIn;
          end else begin
            state_d  = StTurnIn;
            ta_cnt_d = TaLoad;
          end
        end
      end
      StTurnIn: begin
        if (dir_out_i) begin
          state_d  = StTurnOut;
          ta_cnt_d = TaLoad;
        end else if (ta_cnt_q <= TaW'(1)) begin
          state_d = StIn;
        end else begin
          ta_cnt_d = ta_cnt_q - TaW'(1);
        end
      end
      default: state_d = StIn;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIn;
      ta_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ta_cnt_q <= ta_cnt_d;
    end
  end

  // Pad-side outputs follow the state register one edge later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_oe_no    <= 1'b1;
      out_active_o <= 1'b0;
      busy_o       <= 1'b0;
      pad_pu_o     <= 1'b0;
      pad_pd_o     <= 1'b0;
      pad_drv_o    <= 4'h0;
      pad_data_o   <= 1'b0;
    end else begin
      pad_oe_no    <= (state_q != StOut);
      out_active_o <= (state_q == StOut);
      busy_o       <= (state_q == StTurnOut) || (state_q == StTurnIn);
      pad_pu_o     <= (cfg_pull_i == 2'b01) && (state_q != StOut);
      pad_pd_o     <= (cfg_pull_i == 2'b10) && (state_q != StOut);
      pad_drv_o    <= cfg_drv_i;
      if (out_active_o) begin
        pad_data_o <= out_data_i;
      end
    end
  end

  assign sample     = sync_q[SYNC_STAGES-1];
  assign flt_update = (sample != in_data_o) && (flt_cnt_q == FltW'(FILTER_DEPTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      flt_cnt_q <= '0;
      in_data_o <= 1'b0;
      in_edge_o <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pad_data_i};
      in_edge_o <= flt_update && in_valid_o;
      if (sample == in_data_o || flt_update) begin
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FltW'(1);
      end
      if (flt_update) begin
        in_data_o <= sample;
      end
    end
  end

  // Input data is only trusted once the sync/filter pipeline has refilled in input mode.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      settle_q   <= '0;
      in_valid_o <= 1'b0;
    end else if (state_q != StIn) begin
      settle_q   <= '0;
      in_valid_o <= 1'b0;
    end else if (!in_valid_o) begin
      if (settle_q == SetW'(SettleCycles - 1)) begin
        in_valid_o <= 1'b1;
      end else begin
        settle_q <= settle_q + SetW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tc_digital_io_ctrl.sv
// Self-checking bench for tc_digital_io_ctrl: directed test-plan steps followed by random
// traffic, all checked against a cycle model built from the behavioural rules.
module tb_tc_digital_io_ctrl;

  localparam int TA = 2;
  localparam int SYNC = 2;
  localparam int FD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dir_out = 1'b0;
  logic       out_data = 1'b0;
  logic [3:0] cfg_drv = 4'h0;
  logic [1:0] cfg_pull = 2'b00;
  logic       pad_in = 1'b0;
  logic       in_data, in_valid, in_edge, out_active, busy, pad_data, pad_oe_n, pad_pu, pad_pd;
  logic [3:0] pad_drv;

  tc_digital_io_ctrl #(
    .TURNAROUND_CYCLES(TA),
    .SYNC_STAGES      (SYNC),
    .FILTER_DEPTH     (FD)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .dir_out_i   (dir_out),
    .out_data_i  (out_data),
    .cfg_drv_i   (cfg_drv),
    .cfg_pull_i  (cfg_pull),
    .in_data_o   (in_data),
    .in_valid_o  (in_valid),
    .in_edge_o   (in_edge),
    .out_active_o(out_active),
    .busy_o      (busy),
    .pad_data_o  (pad_data),
    .pad_data_i  (pad_in),
    .pad_oe_no   (pad_oe_n),
    .pad_drv_o   (pad_drv),
    .pad_pu_o    (pad_pu),
    .pad_pd_o    (pad_pd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model: mode 0 = input, 1 = hi-Z heading out, 2 = driving, 3 = hi-Z heading in.
  int   m_mode = 0;
  int   m_left = 0;
  int   m_settle = 0;
  int   m_run = 0;
  bit   m_hist[SYNC];
  bit   e_oe_n = 1, e_act = 0, e_busy = 0, e_pu = 0, e_pd = 0, e_pdata = 0;
  bit   e_in = 0, e_valid = 0, e_edge = 0;
  bit [3:0] e_drv = 0;

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit d, input bit od, input bit [3:0] drv,
                            input bit [1:0] pull, input bit pin);
    int  old_mode;
    bit  old_act, old_valid, smp;
    if (r) begin
      m_mode = 0; m_left = 0; m_settle = 0; m_run = 0;
      for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
      e_oe_n = 1; e_act = 0; e_busy = 0; e_pu = 0; e_pd = 0; e_pdata = 0;
      e_in = 0; e_valid = 0; e_edge = 0; e_drv = 0;
      return;
    end
    old_mode = m_mode; old_act = e_act; old_valid = e_valid;
    smp = m_hist[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = pin;
    e_oe_n = (old_mode != 2);
    e_act  = (old_mode == 2);
    e_busy = (old_mode == 1) || (old_mode == 3);
    e_pu   = (pull == 2'b01) && (old_mode != 2);
    e_pd   = (pull == 2'b10) && (old_mode != 2);
    e_drv  = drv;
    if (old_act) e_pdata = od;
    if (old_mode != 0) begin
      e_valid = 0; m_settle = 0;
    end else if (!e_valid) begin
      m_settle++;
      if (m_settle == SYNC + FD) e_valid = 1;
    end
    e_edge = 0;
    if (smp != e_in) begin
      m_run++;
      if (m_run == FD) begin
        e_in = smp; m_run = 0; e_edge = old_valid;
      end
    end else begin
      m_run = 0;
    end
    case (old_mode)
      0: if (d) begin
        if (TA == 0) m_mode = 2; else begin m_mode = 1; m_left = TA; end
      end
      1: if (!d) m_mode = 0; else begin m_left--; if (m_left == 0) m_mode = 2; end
      2: if (!d) begin
        if (TA == 0) m_mode = 0; else begin m_mode = 3; m_left = TA; end
      end
      default: if (d) begin m_mode = 1; m_left = TA; end
               else begin m_left--; if (m_left == 0) m_mode = 0; end
    endcase
  endtask

  task automatic cmp_all();
    chk("pad_oe_no", pad_oe_n, e_oe_n);
    chk("out_active", out_active, e_act);
    chk("busy", busy, e_busy);
    chk("pad_pu", pad_pu, e_pu);
    chk("pad_pd", pad_pd, e_pd);
    chk("pad_drv", pad_drv, e_drv);
    chk("pad_data", pad_data, e_pdata);
    chk("in_data", in_data, e_in);
    chk("in_valid", in_valid, e_valid);
    chk("in_edge", in_edge, e_edge);
  endtask

  // One clock edge: inputs captured before the edge, outputs compared 1 time unit after it.
  task automatic step();
    bit r, d, od, pin;
    bit [3:0] drv;
    bit [1:0] pull;
    r = rst; d = dir_out; od = out_data; drv = cfg_drv; pull = cfg_pull; pin = pad_in;
    @(posedge clk);
    model_edge(r, d, od, drv, pull, pin);
    #1;
    cmp_all();
  endtask

  initial begin
    int hold;
    #2;
    step(); step();
    rst = 1'b0;
    // Settle after reset: in_valid rises on the 5th edge.
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) chk("reset_oe_n", pad_oe_n, 1);
      if (i == 4) chk("settle_not_yet", in_valid, 0);
      if (i == 5) chk("settle_done", in_valid, 1);
    end
    // Clean 0->1 on the pad: accepted exactly 5 edges later with a single edge pulse.
    pad_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 4) chk("rise_not_yet", in_data, 0);
      if (i == 5) begin chk("rise_data", in_data, 1); chk("rise_edge", in_edge, 1); end
      if (i == 6) chk("rise_edge_gone", in_edge, 0);
    end
    // Two-cycle glitch low is rejected.
    pad_in = 1'b0; step(); step();
    pad_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("glitch_data", in_data, 1);
      chk("glitch_edge", in_edge, 0);
    end
    // Go to output mode with pull-up and drive strength configured.
    cfg_pull = 2'b01; cfg_drv = 4'hA; out_data = 1'b1; dir_out = 1'b1;
    step();
    out_data = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) begin chk("to_busy1", busy, 1); chk("to_valid", in_valid, 0); end
      if (i == 2) begin chk("to_busy2", busy, 1); chk("to_oe_hiz", pad_oe_n, 1); end
      if (i == 3) begin chk("to_oe", pad_oe_n, 0); chk("to_active", out_active, 1); end
      if (i == 4) chk("to_pad_data", pad_data, 1);
      if (i == 5) begin chk("out_pu", pad_pu, 0); chk("out_drv", pad_drv, 4'hA); end
    end
    // Release: hi-Z next edge, pull-up returns, input valid 5 edges after reentering input mode.
    dir_out = 1'b0;
    step();
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 1) begin chk("ti_oe", pad_oe_n, 1); chk("ti_pu", pad_pu, 1); end
      if (i == 1 || i == 2) chk("ti_busy", busy, 1);
      if (i == 3) chk("ti_busy_end", busy, 0);
      if (i == 6) chk("ti_valid_wait", in_valid, 0);
      if (i == 7) chk("ti_valid", in_valid, 1);
    end
    // One-cycle request aborts inside the turnaround window.
    dir_out = 1'b1; step();
    dir_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_oe", pad_oe_n, 1);
      chk("abort_active", out_active, 0);
    end
    // Reset while driving returns to hi-Z on the next edge.
    dir_out = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_oe", pad_oe_n, 0);
    rst = 1'b1; step();
    chk("mid_rst_oe", pad_oe_n, 1);
    rst = 1'b0; dir_out = 1'b0;
    // Random traffic against the model.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        pad_in = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 6);
      end
      hold--;
      if ($urandom_range(0, 7) == 0) dir_out = ~dir_out;
      out_data = 1'($urandom_range(0, 1));
      cfg_drv  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) cfg_pull = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 400) == 0);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
